// File: rtl/dht_poll_scheduler_pkg.sv
// rtl/dht_poll_scheduler_pkg.sv - shared types and constants for the DHT poll scheduler
// Purpose: FSM state encoding and width helpers used by the scheduler and its prescaler.
// Ports: none (package).
package dht_poll_scheduler_pkg;

    // Seven scheduler states in a 3-bit encoding; 3'd7 is unused.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CHECK   = 3'd4,
        ST_PUBLISH = 3'd5,
        ST_RETRY   = 3'd6
    } state_e;

    // Width of the millisecond prescaler counter, $clog2(CLK_HZ/1000), kept >= 1.
    function automatic int ms_tick_width(input int clk_hz);
        int div;
        div = clk_hz / 1000;
        return (div > 1) ? $clog2(div) : 1;
    endfunction

    // Bits needed to hold values 0..n-1, kept >= 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dht_poll_scheduler_ms_tick_gen.sv
// rtl/dht_poll_scheduler_ms_tick_gen.sv - millisecond tick prescaler
// Purpose: one-cycle tick every CLK_HZ/1000 clock cycles, shared by all ms counters.
// Ports: clk, rst (async active-low), tick (one-cycle pulse per millisecond).
module ms_tick_gen
    import dht_poll_scheduler_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV = CLK_HZ / 1000;
    localparam int W   = ms_tick_width(CLK_HZ);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dht_poll_scheduler.sv
// rtl/dht_poll_scheduler.sv - DHT sensor read scheduler with gap, timeout, retry and checksum
// Purpose: decides when a sensor read runs (auto-poll, button, retry), enforces the
//   minimum inter-read gap and per-read timeout, checks the checksum and publishes samples.
// Ports: clk, rst (async active-low); auto_en, btn_req (requests); rd_start/rd_done/rd_data
//   (reader handshake); rh_int, rh_dec, temp_int, temp_dec, sample_valid (published sample);
//   fail (sticky), err_count (saturating), busy (not IDLE).
module dht_poll_scheduler
    import dht_poll_scheduler_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int POLL_MS    = 2000,
    parameter int MIN_GAP_MS = 1000,
    parameter int TIMEOUT_MS = 30,
    parameter int MAX_RETRY  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        auto_en,
    input  logic        btn_req,
    output logic        rd_start,
    input  logic        rd_done,
    input  logic [39:0] rd_data,
    output logic [7:0]  rh_int,
    output logic [7:0]  rh_dec,
    output logic [7:0]  temp_int,
    output logic [7:0]  temp_dec,
    output logic        sample_valid,
    output logic        fail,
    output logic [7:0]  err_count,
    output logic        busy
);

    localparam int GAP_W  = cnt_width(MIN_GAP_MS + 1);
    localparam int TO_W   = cnt_width(TIMEOUT_MS + 1);
    localparam int POLL_W = cnt_width(POLL_MS);

    localparam logic [GAP_W-1:0]  GAP_SAT   = GAP_W'(MIN_GAP_MS);
    localparam logic [TO_W-1:0]   TO_LIM    = TO_W'(TIMEOUT_MS);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_MS - 1);
    localparam logic [2:0]        RETRY_LIM = 3'(MAX_RETRY);

    state_e state_q, state_d;

    logic              ms_tick;
    logic              btn_q;
    logic              pend_q, pend_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [POLL_W-1:0] poll_q, poll_d;
    logic [2:0]        retry_q, retry_d;
    logic [39:0]       cap_q, cap_d;
    logic [31:0]       sample_q, sample_d;
    logic              sample_valid_q, sample_valid_d;
    logic              fail_q, fail_d;
    logic [7:0]        err_q, err_d;
    logic              rd_start_q, rd_start_d;
    logic              busy_q, busy_d;

    logic       poll_fire;
    logic       req;
    logic [7:0] sum8;
    logic       csum_ok;
    logic       retry_left;

    ms_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_ms_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (ms_tick)
    );

    // Poll fires on the tick that would take the timer past POLL_MS-1, so the
    // start-to-start period is exactly POLL_MS ticks.
    assign poll_fire = auto_en && ms_tick && (poll_q == POLL_LAST);
    // A button edge and a poll fire in the same cycle collapse into one request.
    assign req       = (btn_req && !btn_q) || poll_fire;

    assign sum8       = cap_q[39:32] + cap_q[31:24] + cap_q[23:16] + cap_q[15:8];
    assign csum_ok    = (sum8 == cap_q[7:0]);
    assign retry_left = (retry_q < RETRY_LIM);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; rd_done is only looked at in WAIT and beats a same-cycle timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (req || pend_q) state_d = ST_ARM;
            ST_ARM:     if (gap_q >= GAP_SAT) state_d = ST_START;
            ST_START:   state_d = ST_WAIT;
            ST_WAIT: begin
                if (rd_done) begin
                    state_d = ST_CHECK;
                end else if (to_q >= TO_LIM) begin
                    state_d = ST_RETRY;
                end
            end
            ST_CHECK:   state_d = csum_ok ? ST_PUBLISH : ST_RETRY;
            ST_PUBLISH: state_d = ST_IDLE;
            ST_RETRY:   state_d = retry_left ? ST_ARM : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        pend_d         = pend_q;
        gap_d          = gap_q;
        to_d           = to_q;
        poll_d         = poll_q;
        retry_d        = retry_q;
        cap_d          = cap_q;
        sample_d       = sample_q;
        fail_d         = fail_q;
        err_d          = err_q;
        sample_valid_d = (state_d == ST_PUBLISH);
        rd_start_d     = (state_d == ST_START);
        busy_d         = (state_d != ST_IDLE);

        if (!auto_en) begin
            poll_d = '0;
        end else if (ms_tick) begin
            poll_d = poll_fire ? '0 : poll_q + POLL_W'(1);
        end

        // IDLE consumes the flag; anywhere else a request just sets it.
        if (state_q == ST_IDLE) begin
            pend_d = 1'b0;
        end else if (req) begin
            pend_d = 1'b1;
        end

        // Gap counts from the end of a read and saturates at the minimum gap.
        if ((state_d == ST_CHECK) || (state_d == ST_RETRY)) begin
            gap_d = '0;
        end else if (ms_tick && (gap_q < GAP_SAT)) begin
            gap_d = gap_q + GAP_W'(1);
        end

        if (state_q == ST_START) begin
            to_d = '0;
        end else if ((state_q == ST_WAIT) && ms_tick && (to_q < TO_LIM)) begin
            to_d = to_q + TO_W'(1);
        end

        if ((state_q == ST_WAIT) && rd_done) begin
            cap_d = rd_data;
        end

        if (state_d == ST_PUBLISH) begin
            sample_d = cap_q[39:8];
            fail_d   = 1'b0;
            retry_d  = '0;
        end

        if (state_q == ST_RETRY) begin
            if (err_q != 8'hFF) begin
                err_d = err_q + 8'd1;
            end
            if (retry_left) begin
                retry_d = retry_q + 3'd1;
            end else begin
                retry_d = '0;
                fail_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_q          <= 1'b0;
            pend_q         <= 1'b0;
            gap_q          <= GAP_SAT;
            to_q           <= '0;
            poll_q         <= '0;
            retry_q        <= '0;
            cap_q          <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            fail_q         <= 1'b0;
            err_q          <= '0;
            rd_start_q     <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            btn_q          <= btn_req;
            pend_q         <= pend_d;
            gap_q          <= gap_d;
            to_q           <= to_d;
            poll_q         <= poll_d;
            retry_q        <= retry_d;
            cap_q          <= cap_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            fail_q         <= fail_d;
            err_q          <= err_d;
            rd_start_q     <= rd_start_d;
            busy_q         <= busy_d;
        end
    end

    assign rd_start     = rd_start_q;
    assign busy         = busy_q;
    assign sample_valid = sample_valid_q;
    assign fail         = fail_q;
    assign err_count    = err_q;
    assign rh_int       = sample_q[31:24];
    assign rh_dec       = sample_q[23:16];
    assign temp_int     = sample_q[15:8];
    assign temp_dec     = sample_q[7:0];

endmodule

// File: tb/tb_dht_poll_scheduler.sv
// tb/tb_dht_poll_scheduler.sv - self-checking bench for dht_poll_scheduler
module tb_dht_poll_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        auto_en = 1'b0;
    logic        btn_req = 1'b0;
    logic        rd_start;
    logic        rd_done;
    logic [39:0] rd_data;
    logic [7:0]  rh_int, rh_dec, temp_int, temp_dec;
    logic        sample_valid;
    logic        fail;
    logic [7:0]  err_count;
    logic        busy;

    dht_poll_scheduler #(
        .CLK_HZ     (4000),
        .POLL_MS    (20),
        .MIN_GAP_MS (5),
        .TIMEOUT_MS (3),
        .MAX_RETRY  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .auto_en      (auto_en),
        .btn_req      (btn_req),
        .rd_start     (rd_start),
        .rd_done      (rd_done),
        .rd_data      (rd_data),
        .rh_int       (rh_int),
        .rh_dec       (rh_dec),
        .temp_int     (temp_int),
        .temp_dec     (temp_dec),
        .sample_valid (sample_valid),
        .fail         (fail),
        .err_count    (err_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reader model / monitor state
    bit          resp_en = 1'b0;
    int          resp_delay = 2;
    logic [39:0] resp_frame = '0;
    int          resp_cnt = -1;
    int          inj_req = 0;
    int          inj_ack = 0;
    int          start_cnt = 0;
    int          last_start = 0;
    int          end_cyc = 0;
    bit          have_end = 1'b0;
    int          min_gap_bad = 0;
    int          sv_cnt = 0;
    int          sv_lat = 0;

    typedef struct {
        logic [39:0] frame;
        bit          respond;
        int          exp_starts;
        int          exp_sv;
        bit          exp_fail;
        int          exp_err;
        logic [31:0] exp_out;
        bit          chk_to;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Reader: answers each rd_start after resp_delay cycles; also counts events.
    initial begin
        rd_done = 1'b0;
        rd_data = '0;
        forever begin
            @(posedge clk);
            #1;
            rd_done = 1'b0;
            if (resp_cnt == 0) begin
                rd_done  = 1'b1;
                rd_data  = resp_frame;
                end_cyc  = cyc;
                have_end = 1'b1;
            end else if (inj_req != inj_ack) begin
                rd_done = 1'b1;
                rd_data = resp_frame;
                inj_ack = inj_req;
            end
            if (resp_cnt >= 0) resp_cnt--;
            if (rd_start) begin
                start_cnt++;
                if (have_end && (cyc - end_cyc) < 16) min_gap_bad++;
                last_start = cyc;
                if (resp_en) resp_cnt = resp_delay - 1;
            end
            if (sample_valid) begin
                sv_cnt++;
                sv_lat = cyc - end_cyc;
            end
        end
    end

    task automatic press(output int lat);
        int s0;
        int bc;
        s0 = start_cnt;
        btn_req = 1'b1;
        bc = cyc;
        step();
        btn_req = 1'b0;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (start_cnt != s0) begin
                lat = last_start - bc;
                break;
            end
            step();
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   s0, v0, lat, fall;
        bit   idle;
        v = vecs[idx];
        repeat (30) step();
        resp_en    = v.respond;
        resp_frame = v.frame;
        resp_delay = 2;
        s0 = start_cnt;
        v0 = sv_cnt;
        press(lat);
        check($sformatf("v%0d_latency", idx), 64'(lat), 64'(2));
        idle = 1'b0;
        fall = 0;
        for (int i = 0; i < 400; i++) begin
            if (!busy) begin
                idle = 1'b1;
                fall = cyc;
                break;
            end
            step();
        end
        check($sformatf("v%0d_idle", idx), 64'(idle), 64'(1));
        check($sformatf("v%0d_starts", idx), 64'(start_cnt - s0), 64'(v.exp_starts));
        check($sformatf("v%0d_sv", idx), 64'(sv_cnt - v0), 64'(v.exp_sv));
        check($sformatf("v%0d_fail", idx), 64'(fail), 64'(v.exp_fail));
        check($sformatf("v%0d_err", idx), 64'(err_count), 64'(v.exp_err));
        check($sformatf("v%0d_out", idx), 64'({rh_int, rh_dec, temp_int, temp_dec}), 64'(v.exp_out));
        check($sformatf("v%0d_gap", idx), 64'(min_gap_bad), 64'(0));
        if (v.exp_sv != 0) check($sformatf("v%0d_sv_lat", idx), 64'(sv_lat), 64'(2));
        if (v.chk_to) check_range($sformatf("v%0d_timeout", idx), fall - last_start, 10, 15);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int starts[5];
        int n, prev, p, s0, v0, lat;

        vecs[0] = '{40'h23_00_19_05_41, 1'b1, 1, 1, 1'b0, 0, 32'h23_00_19_05, 1'b0};
        vecs[1] = '{40'h23_00_19_05_00, 1'b1, 3, 0, 1'b1, 3, 32'h23_00_19_05, 1'b0};
        vecs[2] = '{40'h00_00_00_00_00, 1'b0, 3, 0, 1'b1, 6, 32'h23_00_19_05, 1'b1};
        vecs[3] = '{40'hFF_80_40_41_00, 1'b1, 1, 1, 1'b0, 6, 32'hFF_80_40_41, 1'b0};
        vecs[4] = '{40'h01_02_03_04_0A, 1'b1, 1, 1, 1'b0, 6, 32'h01_02_03_04, 1'b0};

        // Reset state
        repeat (3) step();
        check("reset_outputs", 64'({rd_start, sample_valid, fail, busy, err_count,
                                    rh_int, rh_dec, temp_int, temp_dec}), 64'(0));
        rst = 1'b1;
        step();
        check("post_reset_busy", 64'(busy), 64'(0));

        for (int i = 0; i < 5; i++) run_vec(i);

        // Auto-poll period and a button edge coinciding with a poll fire
        resp_en    = 1'b1;
        resp_delay = 4;
        resp_frame = 40'h30_01_18_02_4B;
        auto_en    = 1'b1;
        n    = 0;
        prev = start_cnt;
        for (int i = 0; i < 600 && n < 5; i++) begin
            step();
            if (start_cnt != prev) begin
                starts[n] = last_start;
                n++;
                prev = start_cnt;
            end
        end
        check("auto_count", 64'(n), 64'(5));
        for (int i = 1; i < 5; i++)
            check_range($sformatf("auto_period%0d", i), starts[i] - starts[i-1], 76, 84);
        check("auto_out", 64'({rh_int, rh_dec, temp_int, temp_dec}), 64'(32'h30_01_18_02));
        p = last_start;
        while (cyc < p + 78) step();
        s0 = start_cnt;
        btn_req = 1'b1;
        step();
        btn_req = 1'b0;
        repeat (70) step();
        auto_en = 1'b0;
        check("merge_starts", 64'(start_cnt - s0), 64'(1));
        check("merge_start_cycle", 64'(last_start - p), 64'(80));
        repeat (20) step();

        // Button edge during WAIT: one extra read after the gap
        repeat (30) step();
        resp_delay = 6;
        resp_frame = 40'h01_02_03_04_0A;
        s0 = start_cnt;
        v0 = sv_cnt;
        press(lat);
        check("wait_btn_latency", 64'(lat), 64'(2));
        repeat (2) step();
        btn_req = 1'b1;
        step();
        btn_req = 1'b0;
        repeat (150) step();
        check("wait_btn_starts", 64'(start_cnt - s0), 64'(2));
        check("wait_btn_sv", 64'(sv_cnt - v0), 64'(2));
        check("wait_btn_gap", 64'(min_gap_bad), 64'(0));
        check("wait_btn_idle", 64'(busy), 64'(0));

        // Reset during WAIT, then a stray rd_done after release
        repeat (30) step();
        resp_en = 1'b0;
        press(lat);
        check("rst_seq_latency", 64'(lat), 64'(2));
        repeat (2) step();
        check("rst_seq_busy_before", 64'(busy), 64'(1));
        rst = 1'b0;
        #1;
        check("rst_async_outputs", 64'({rd_start, sample_valid, fail, busy, err_count,
                                        rh_int, rh_dec, temp_int, temp_dec}), 64'(0));
        step();
        rst = 1'b1;
        step();
        s0 = start_cnt;
        v0 = sv_cnt;
        inj_req++;
        repeat (6) step();
        check("stray_done_sv", 64'(sv_cnt - v0), 64'(0));
        check("stray_done_starts", 64'(start_cnt - s0), 64'(0));
        check("stray_done_state", 64'({busy, fail, err_count, rh_int, temp_int}), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
